// File: rtl/left_shifter_seq_if.sv
// Request/result handshake bundle for the sequential left shifter.
// Master drives requests and the result acknowledge; slave is the shifter.
interface left_shifter_seq_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/left_shifter_seq.sv
// Sequential left rotate / logical shifter, one bit position per cycle.
// Latency in_amt+1 cycles from accept to out_valid; result held in HOLD until out_ready.
module left_shifter_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    left_shifter_seq_if.slave   bus,
    output logic                busy
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    cnt;
        logic             mode;
    } op_t;

    state_t state_q, state_d;
    op_t    op_q, op_d;
    logic   accept;

    // in_ready is a pure state decode so it never depends on in_valid
    assign bus.in_ready  = (state_q == IDLE) & rst_n;
    assign bus.out_valid = (state_q == HOLD) & rst_n;
    assign bus.out_data  = op_q.data;
    assign busy          = (state_q != IDLE) & rst_n;
    assign accept        = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d.data = bus.in_data;
                    op_d.cnt  = bus.in_amt;
                    op_d.mode = bus.in_mode;
                    state_d   = (bus.in_amt == '0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                op_d.data = op_q.mode ? {op_q.data[WIDTH-2:0], 1'b0}
                                      : {op_q.data[WIDTH-2:0], op_q.data[WIDTH-1]};
                op_d.cnt  = op_q.cnt - 1'b1;
                // cnt of 0 cannot occur here; treating it as last step keeps SHIFT bounded
                if (op_q.cnt <= AW'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_left_shifter_seq.sv
// Directed bench for left_shifter_seq: latency, results, backpressure and reset abort.
module tb_left_shifter_seq;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    left_shifter_seq_if #(.WIDTH(WIDTH)) bus ();

    left_shifter_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency, optionally stall the result, then release it
    task automatic run_op(input logic [7:0] d, input logic [2:0] amt, input logic mode,
                          input logic [7:0] exp, input int hold);
        int n;
        @(negedge clk);
        check("ready_before_req", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = amt;
        bus.in_mode   = mode;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n = 1;
        bus.in_data = ~d;
        bus.in_amt  = amt + 3'd1;
        bus.in_mode = ~mode;
        while (!bus.out_valid && n < 4 * WIDTH) begin
            @(negedge clk);
            n++;
            bus.in_data = 8'($urandom);
        end
        check("latency", 32'(n), 32'(int'(amt) + 1));
        check("result", 32'(bus.out_data), 32'(exp));
        check("busy_hold", 32'(busy), 32'd1);
        check("ready_hold", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_data = 8'($urandom);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'(exp));
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("data_kept", 32'(bus.out_data), 32'(exp));
        check("ready_after", 32'(bus.in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_post_rst", 32'(bus.in_ready), 32'd1);

        run_op(8'h81, 3'd1, 1'b0, 8'h03, 0);
        run_op(8'hB5, 3'd3, 1'b1, 8'hA8, 0);
        run_op(8'h5A, 3'd0, 1'b0, 8'h5A, 0);
        run_op(8'h5A, 3'd0, 1'b1, 8'h5A, 0);
        run_op(8'h01, 3'd7, 1'b0, 8'h80, 0);
        run_op(8'h01, 3'd7, 1'b1, 8'h80, 0);
        run_op(8'h03, 3'd7, 1'b1, 8'h80, 0);
        run_op(8'h03, 3'd7, 1'b0, 8'h81, 0);
        run_op(8'h96, 3'd4, 1'b0, 8'h69, 0);
        run_op(8'h96, 3'd4, 1'b1, 8'h60, 0);
        run_op(8'hC3, 3'd2, 1'b0, 8'h0F, 0);
        run_op(8'h81, 3'd1, 1'b0, 8'h03, 5);

        // Reset during SHIFT must discard the operation entirely
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_amt   = 3'd6;
        bus.in_mode  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_data_end", 32'(bus.out_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/left_shifter_seq.md
LEFT_SHIFTER_SEQ -- requirements
Module: left_shifter_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand width; SHALL be a power of two, at least 2; AW = log2(WIDTH) SHALL be a derived localparam.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present on in_data/in_amt/in_mode.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_data  input  WIDTH  operand.
REQ-007 in_amt  input  AW  left shift/rotate amount, 0..WIDTH-1.
REQ-008 in_mode  input  1  0 = rotate left (MSB wraps to LSB); 1 = logical left (zero fill).
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  WIDTH  result register.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SHIFT, HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE with rst_n high; it is a decode of state with no combinational path from in_valid.
REQ-015 Accept = in_valid & in_ready; on accept, data register <= in_data, count <= in_amt, mode register <= in_mode.
REQ-016 On accept with in_amt == 0, next state SHALL be HOLD; otherwise next state SHALL be SHIFT.
REQ-017 In SHIFT, each cycle: data <= {data[WIDTH-2:0], data[WIDTH-1]} for rotate, or {data[WIDTH-2:0], 1'b0} for logical; count <= count - 1.
REQ-018 In SHIFT, when count == 1 at a clock edge, that edge SHALL perform the final step and move to HOLD.
REQ-019 Latency: out_valid SHALL rise exactly in_amt + 1 cycles after the accept edge (amt 0 -> 1 cycle; amt WIDTH-1 -> WIDTH cycles).
REQ-020 out_valid SHALL be 1 only in HOLD; out_data SHALL equal the data register and stay stable while in HOLD.
REQ-021 In HOLD, out_ready = 1 SHALL return the FSM to IDLE on that edge; out_valid SHALL drop the next cycle; out_data SHALL keep its last value.
REQ-022 In HOLD, out_ready = 0 SHALL hold state, out_valid and out_data indefinitely (backpressure).
REQ-023 Inputs in_data/in_amt/in_mode SHALL be ignored outside the accept cycle; changes during SHIFT/HOLD SHALL NOT affect the result.
REQ-024 No overlap: a new request is accepted no earlier than the cycle after HOLD exits (minimum issue interval = in_amt + 2 cycles with out_ready tied 1).
REQ-025 Rotate result SHALL equal the combinational left rotation of in_data by in_amt; logical result SHALL equal in_data << in_amt truncated to WIDTH.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 While rst_n == 0 at a clock edge: state <= IDLE, out_data <= 0, count <= 0, mode register <= 0; out_valid = 0, busy = 0, in_ready = 0.
REQ-028 Reset asserted mid-SHIFT or in HOLD SHALL abort the operation with no result delivered; no out_valid pulse SHALL follow.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-030 Rotate: in_data 0x81, amt 1, mode 0 -> out_valid 2 cycles after accept, out_data 0x03.
REQ-031 Logical: in_data 0xB5, amt 3, mode 1 -> out_valid 4 cycles after accept, out_data 0xA8.
REQ-032 Zero amount: in_data 0x5A, amt 0, either mode -> out_valid 1 cycle after accept, out_data 0x5A.
REQ-033 Max amount: in_data 0x01, amt 7, mode 0 -> out_valid 8 cycles after accept, out_data 0x80; same with mode 1 -> 0x80; in_data 0x03, amt 7, mode 1 -> 0x80.
REQ-034 Backpressure: hold out_ready 0 for 5 cycles in HOLD -> out_valid and out_data stable, in_ready 0; in_valid with new data ignored; out_ready 1 -> IDLE next cycle.
REQ-035 Reset mid-op: accept 0xFF, amt 6, then rst_n 0 for 1 cycle during SHIFT -> out_valid never rises, out_data 0x00, in_ready 1 the cycle after reset release.
